// File: rtl/neg_bus_driver_timed_pkg.sv
// Shared bus-driver definitions: FSM state encoding and default timing,
// common to the negative- and positive-bus driver variants.
package neg_bus_driver_timed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_t;

  localparam int DRIVE_CYC_DEF  = 8;
  localparam int SETTLE_CYC_DEF = 2;
  localparam int WIDTH_DEF      = 12;

endpackage

// File: rtl/neg_bus_driver_timed_chan.sv
// One open-drain bus line: pulls low only when driving and selected,
// and keeps a sticky stuck-high flag from readback.
module neg_bus_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic drive,
  input  logic check,
  input  logic clear,
  input  logic sel,
  input  logic bus_in,
  output logic bus_out,
  output logic fault
);

  assign bus_out = (drive && sel) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (clear) begin
      fault <= 1'b0;
    end else if (check && sel && bus_in) begin
      fault <= 1'b1;
    end
  end

endmodule

// File: rtl/neg_bus_driver_timed.sv
// Timed negative-bus driver: load -> settle -> drive low -> release -> done.
//   state   | meaning
//   IDLE    | bus released, waiting for load
//   SETTLE  | word latched, bus still released for SETTLE_CYC clocks
//   DRIVE   | selected lines pulled low for DRIVE_CYC clocks
//   RELEASE | bus released for one clock, done follows
module neg_bus_driver_timed
  import neg_bus_driver_timed_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int DRIVE_CYC  = DRIVE_CYC_DEF,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             abort,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy,
  output logic             driving,
  output logic             done,
  output logic [WIDTH-1:0] fault
);

  localparam int SETTLE_M1 = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_M1);
  localparam logic [CNT_W-1:0] DRIVE_LD  = CNT_W'(DRIVE_CYC - 1);

  bus_state_t       state;
  bus_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] latch;
  logic             accept;
  logic             check;

  assign accept = (state == ST_IDLE) && load && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      latch <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= (state == ST_RELEASE) && !abort;
      if (accept) begin
        latch <= d;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            if (SETTLE_CYC > 0) begin
              state_next = ST_SETTLE;
              cnt_next   = SETTLE_LD;
            end else begin
              state_next = ST_DRIVE;
              cnt_next   = DRIVE_LD;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state_next = ST_DRIVE;
            cnt_next   = DRIVE_LD;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            state_next = ST_RELEASE;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    driving = (state == ST_DRIVE);
  end

  // The first drive clock is skipped for fault checks: the bus is still settling.
  assign check = driving && (cnt != DRIVE_LD);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    neg_bus_chan u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .drive  (driving),
      .check  (check),
      .clear  (accept),
      .sel    (latch[g]),
      .bus_in (bus_in[g]),
      .bus_out(bus_out[g]),
      .fault  (fault[g])
    );
  end

endmodule
